restador_serie_param: RTL
=========================

# restador_serie_param

Parametrised multi-cycle binary subtractor, the successor of the 4-bit combinational `restador_binario`. It computes `A - B - Bin` over a configurable width, processing `PASO` bits per clock with a registered borrow chain, and hands results back with a start/done handshake. It also reports unsigned borrow, signed overflow and zero flags. It sits in the arithmetic datapath wherever a wide subtraction must not form a long combinational borrow path.

## Interface
- `ANCHO`, 16: operand and result width in bits.
- `PASO`, 4: bits processed per cycle. Must divide `ANCHO`; N = ANCHO/PASO cycles per operation.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inicio` in 1: start request, sampled on `clk`.
- `A` in ANCHO: minuend, captured on the accept edge.
- `B` in ANCHO: subtrahend, captured on the accept edge.
- `Bin` in 1: borrow-in, for chaining; captured on the accept edge.
- `Resultado` out ANCHO: `(A - B - Bin) mod 2^ANCHO`.
- `Borrow` out 1: 1 iff `A < B + Bin` (unsigned).
- `Desborde` out 1: two's-complement overflow of the subtraction.
- `Cero` out 1: `Resultado == 0`.
- `ocupado` out 1: high while in RESTANDO.
- `listo` out 1: one-cycle completion pulse.

## Operation
- FSM states and transitions:
  - REPOSO: `inicio`=1 → RESTANDO. On this accept edge, latch `A`, `B`, `Bin`; set internal borrow to `Bin`; clear chunk counter.
  - RESTANDO, each edge: subtract chunk k (bits `k*PASO +: PASO`, LSB chunk first) with the registered borrow. Store the chunk result in an internal accumulator, register the chunk borrow-out, increment k.
  - On the edge processing chunk N-1 → FIN.
  - FIN: lasts exactly one cycle, with `listo`=1, then → REPOSO.
- On the edge entering FIN, copy the accumulator to `Resultado` and register the flags:
  - `Borrow` = final chunk borrow-out.
  - `Desborde` = (A[msb] != B[msb]) && (R[msb] != A[msb]).
  - `Cero` = (R == 0).
- Outputs hold their last completed values. They do not change during RESTANDO and change only on entry to FIN.
- `inicio` is ignored in RESTANDO and FIN. There is no queueing and no error flag.
- `A`, `B` and `Bin` may change freely after the accept edge.
- Reset (async, any state, including mid-operation):
  - State → REPOSO.
  - `Resultado`, `Borrow`, `Desborde`, `Cero`, `ocupado`, `listo` = 0.
  - Accumulator, counter and internal borrow cleared.
  - The aborted operation never produces `listo`.
- The reset value of `Cero`=0 is deliberate: it means "no valid result yet".

## Timing
- The accept edge is the rising edge with state=REPOSO and `inicio`=1.
- `ocupado` is high from the cycle after the accept edge for N cycles.
- `listo` is high in cycle N+1 after the accept edge (latency N+1 edges to the edge where `listo` is first sampled high). For N=4 it is sampled high at the 5th edge after accept.
- New results are valid in the same cycle `listo` is high.
- Minimum issue interval is N+2 cycles. `inicio` held high continuously is re-accepted in REPOSO immediately after FIN.
- N=1 (PASO=ANCHO): one RESTANDO cycle, then FIN.
- The borrow path is PASO bits long per cycle. No combinational path exists from inputs to outputs.

## Structure
- Package `restador_pkg`:
  - State typedef `estado_t` {REPOSO, RESTANDO, FIN}.
  - Default `ANCHO`/`PASO` constants.
- Counter width is `$clog2(N)`, minimum 1 bit.
- The `ANCHO % PASO == 0` check is an elaboration-time assertion.
- Sub-module `restador_bloque`: combinational PASO-bit subtractor (`a`, `b`, `bin` → `d`, `bout`), instantiated once and reused each cycle.

## Test plan
- Defaults (16/4), A=9, B=5, Bin=0 → `Resultado`=0x0004, `Borrow`=0, `Desborde`=0, `Cero`=0, `listo` pulse 5 edges after accept, `ocupado` high 4 cycles.
- A=3, B=6 → 0xFFFD, `Borrow`=1, `Desborde`=0. A=0x8000, B=1 → 0x7FFF, `Borrow`=0, `Desborde`=1.
- Cross-chunk borrow: A=0x0100, B=0x0001 → 0x00FF. A=0, B=0, Bin=1 → 0xFFFF, `Borrow`=1. A=5, B=5 → 0, `Cero`=1.
- `inicio` pulsed during RESTANDO with different operands → ignored; first result unchanged; exactly one `listo`.
- `rst_n` low for 1 cycle in the 2nd RESTANDO cycle → all outputs 0 immediately, no `listo`; a new operation afterwards completes correctly.
- ANCHO=8, PASO=8: A=0x80, B=0x01 → 0x7F, `Desborde`=1, `listo` 2 edges after accept. ANCHO=4, PASO=1: A=15, B=1 → 14 after 5 edges.

Source files
------------

// File: rtl/restador_serie_param_pkg.sv
// Shared types and default sizing for the serial subtractor.
package restador_pkg;

    // Control states: idle, chunk-by-chunk subtraction, one-cycle completion.
    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        RESTANDO = 2'd1,
        FIN      = 2'd2
    } estado_t;

    localparam int ANCHO_DEF = 16;
    localparam int PASO_DEF  = 4;

endpackage

// File: rtl/restador_serie_param_if.sv
// Operand/result bundle of the serial subtractor.
//
// Handshake: the consumer accepts a request on the rising edge where it is
// idle and inicio=1; A, B and Bin are captured on that edge only. ocupado is
// high while the subtraction runs; listo pulses for exactly one cycle and
// Resultado/Borrow/Desborde/Cero are valid from that cycle until the next
// completion. Requests made while busy are dropped, not queued.
interface restador_serie_param_if
    import restador_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
);
    logic             inicio;
    logic [ANCHO-1:0] A;
    logic [ANCHO-1:0] B;
    logic             Bin;
    logic [ANCHO-1:0] Resultado;
    logic             Borrow;
    logic             Desborde;
    logic             Cero;
    logic             ocupado;
    logic             listo;

    modport master (
        output inicio, A, B, Bin,
        input  Resultado, Borrow, Desborde, Cero, ocupado, listo
    );

    modport slave (
        input  inicio, A, B, Bin,
        output Resultado, Borrow, Desborde, Cero, ocupado, listo
    );
endinterface

// File: rtl/restador_serie_param_bloque.sv
// PASO-bit combinational subtractor slice: d = a - b - bin, bout = borrow out.
module restador_bloque #(
    parameter int PASO = 4
) (
    input  logic [PASO-1:0] a,
    input  logic [PASO-1:0] b,
    input  logic            bin,
    output logic [PASO-1:0] d,
    output logic            bout
);
    logic [PASO:0] w_dif;

    // One extra bit catches the borrow: it goes high exactly when a < b + bin.
    assign w_dif = {1'b0, a} - {1'b0, b} - {{PASO{1'b0}}, bin};
    assign d     = w_dif[PASO-1:0];
    assign bout  = w_dif[PASO];
endmodule

// File: rtl/restador_serie_param.sv
// Multi-cycle subtractor: A - B - Bin over ANCHO bits, PASO bits per clock,
// borrow carried between chunks in a register so the combinational borrow
// path never exceeds one slice.
module restador_serie_param
    import restador_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF,
    parameter int PASO  = PASO_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    restador_serie_param_if.slave  bus,
    output estado_t                o_estado
);
    localparam int N  = ANCHO / PASO;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    if ((PASO < 1) || (ANCHO % PASO != 0)) begin : g_chk_paso
        $error("restador_serie_param: PASO must divide ANCHO");
    end

    estado_t          r_estado, w_estado_sig;
    logic [ANCHO-1:0] r_a, r_b, r_acc, r_resultado, w_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow, r_borrow_fin, r_desborde, r_cero;
    logic [PASO-1:0]  w_a_trozo, w_b_trozo, w_d;
    logic             w_bout, w_acepta, w_ultimo;

    assign w_acepta = (r_estado == REPOSO) && bus.inicio;
    assign w_ultimo = (r_cnt == ULTIMO);

    // Select chunk r_cnt of the latched operands, and form the accumulator
    // with this cycle's chunk result merged in.
    always_comb begin
        w_a_trozo = '0;
        w_b_trozo = '0;
        w_res     = r_acc;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_trozo = r_a[k*PASO +: PASO];
                w_b_trozo = r_b[k*PASO +: PASO];
                w_res[k*PASO +: PASO] = w_d;
            end
        end
    end

    restador_bloque #(.PASO(PASO)) u_bloque (
        .a    (w_a_trozo),
        .b    (w_b_trozo),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= REPOSO;
        else        r_estado <= w_estado_sig;
    end

    // Next-state logic: accept, run N chunk cycles, one FIN cycle.
    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO:   if (bus.inicio) w_estado_sig = RESTANDO;
            RESTANDO: if (w_ultimo)   w_estado_sig = FIN;
            FIN:                      w_estado_sig = REPOSO;
            default:                  w_estado_sig = REPOSO;
        endcase
    end

    // Datapath: capture on accept, one chunk per RESTANDO cycle, publish
    // result and flags only on the final chunk so outputs hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_borrow     <= 1'b0;
            r_resultado  <= '0;
            r_borrow_fin <= 1'b0;
            r_desborde   <= 1'b0;
            r_cero       <= 1'b0;
        end else if (w_acepta) begin
            r_a      <= bus.A;
            r_b      <= bus.B;
            r_borrow <= bus.Bin;
            r_cnt    <= '0;
            r_acc    <= '0;
        end else if (r_estado == RESTANDO) begin
            r_acc    <= w_res;
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_ultimo) begin
                r_resultado  <= w_res;
                r_borrow_fin <= w_bout;
                r_desborde   <= (r_a[ANCHO-1] != r_b[ANCHO-1]) &&
                                (w_res[ANCHO-1] != r_a[ANCHO-1]);
                r_cero       <= (w_res == '0);
            end
        end
    end

    assign bus.Resultado = r_resultado;
    assign bus.Borrow    = r_borrow_fin;
    assign bus.Desborde  = r_desborde;
    assign bus.Cero      = r_cero;
    assign bus.ocupado   = (r_estado == RESTANDO);
    assign bus.listo     = (r_estado == FIN);
    assign o_estado      = r_estado;
endmodule
